// File: rtl/sort4_sltu.sv
// sort4_sltu: sequential ascending sorter for four unsigned N-bit words.
//
// One shared unsigned less-than comparator (sltu) does one compare-swap per
// cycle on a fixed bubble-sort schedule: pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
// A vector is accepted in IDLE, sorted in exactly 6 SORT cycles, then presented
// in DONE until the consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   producer offers a vector on in_data
//   in_ready   high in IDLE: a vector can be accepted this cycle
//   in_data    element k at [k*N +: N], k = 0..3
//   out_valid  high in DONE: sorted vector on out_data
//   out_ready  consumer accepts out_data this cycle
//   out_data   sorted ascending, smallest at [0 +: N]
//   swaps      number of swaps performed on the current vector (0..6)

// Unsigned strict less-than: lt = (a < b).
module sltu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  assign lt = (a < b);
endmodule

module sort4_sltu #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*N-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_data,
  output logic [2:0]     swaps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] r [4];
  logic [2:0]   step;
  logic [1:0]   j;        // lower index of the pair handled this step
  logic [1:0]   jp;       // j + 1, never wraps since j <= 2
  logic [N-1:0] lo_val;   // r[j]
  logic [N-1:0] hi_val;   // r[j+1]
  logic         comp;     // r[j+1] < r[j], unsigned

  // Bubble-sort schedule: three passes of shrinking length.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    j = 2'd0;
    unique case (step)
      3'd1, 3'd4: j = 2'd1;
      3'd2:       j = 2'd2;
      default:    j = 2'd0;
    endcase
  end

  assign jp     = j + 2'd1;
  assign lo_val = r[j];
  assign hi_val = r[jp];

  sltu #(.N(N)) u_cmp (
    .a  (hi_val),
    .b  (lo_val),
    .lt (comp)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)     state_nx = SORT;
      SORT:    if (step == 3'd5) state_nx = DONE;
      DONE:    if (out_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state register, so they are glitch-free.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register and datapath.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values; the swap below relies on this.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      // NOTE: the element registers are reset too because out_data must read 0
      // after reset; a plain storage array with no visible reset value would
      // normally be left unreset.
      for (int k = 0; k < 4; k++) r[k] <= '0;
      step  <= '0;
      swaps <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 4; k++) r[k] <= in_data[k*N +: N];
            step  <= '0;
            swaps <= '0;
          end
        end
        SORT: begin
          if (comp) begin
            r[j]  <= hi_val;
            r[jp] <= lo_val;
            swaps <= swaps + 3'd1;
          end
          step <= step + 3'd1;
        end
        default: ;  // DONE holds r and swaps stable
      endcase
    end
  end

  assign out_data = {r[3], r[2], r[1], r[0]};

endmodule
